// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage of the 3-stage RV32I pipeline:
// writeback select codes, load funct3 codes, CSR index, reset instruction and load FSM states.
package wb_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD = 7'b000_0011;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC4 = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [11:0] CSR_TOHOST = 12'h51E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HELD = 2'd2
    } ld_state_t;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Load data alignment: selects the byte/half/word addressed by addr and sign- or zero-extends it.
module wb_stage_load_extend
    import wb_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        // Halfword picks by addr[1] only; a misaligned halfword is not trapped.
        half_sel = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            F3_LW:   result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: W pipeline register, load-response FSM, regfile write port,
// tohost CSR and the cycle/instret counters.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            x_valid,
    input  logic [31:0]     x_pc,
    input  logic [31:0]     x_alu,
    input  logic [31:0]     x_inst,
    input  logic [31:0]     x_csr_src,
    input  logic            stall_in,
    input  logic            dmem_busy,
    input  logic            dmem_resp_valid,
    input  logic [31:0]     dmem_rdata,
    output logic [6:0]      ctl_opcode,
    output logic [2:0]      ctl_funct3,
    output logic [11:0]     ctl_csr,
    input  logic [1:0]      wb_sel,
    input  logic            rwe,
    input  logic            csr_we,
    output logic            w_stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [31:0]     rf_wdata,
    output logic [31:0]     csr_tohost,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt,
    output logic [1:0]      dbg_state,
    output logic [31:0]     dbg_inst
);

    logic            w_valid;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_inst;
    logic [XLEN-1:0] w_csr_src;
    logic [XLEN-1:0] ld_buf;
    logic [XLEN-1:0] ld_word;
    logic [XLEN-1:0] ld_data;

    ld_state_t state;
    ld_state_t state_nxt;

    logic advance;
    logic is_load;
    logic rsp;
    logic ld_capture;

    // A busy cache cannot return data, so a response is only honoured when not busy.
    assign rsp     = dmem_resp_valid && !dmem_busy;
    assign is_load = w_valid && (w_inst[6:0] == OP_LOAD);
    assign advance = !stall_in && !w_stall;

    assign ctl_opcode = w_inst[6:0];
    assign ctl_funct3 = w_inst[14:12];
    assign ctl_csr    = w_inst[31:20];
    assign rf_waddr   = w_inst[11:7];
    assign dbg_state  = state;
    assign dbg_inst   = w_inst;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_valid   <= 1'b0;
            w_pc      <= '0;
            w_alu     <= '0;
            w_inst    <= NOP_INST;
            w_csr_src <= '0;
        end else if (advance) begin
            w_valid   <= x_valid;
            w_pc      <= x_pc;
            w_alu     <= x_alu;
            w_inst    <= x_inst;
            w_csr_src <= x_csr_src;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            ld_buf <= '0;
        end else begin
            state <= state_nxt;
            if (ld_capture) begin
                ld_buf <= dmem_rdata;
            end
        end
    end

    // HELD means the word is already buffered and only the external stall blocks retirement.
    always_comb begin
        state_nxt  = state;
        w_stall    = 1'b0;
        ld_capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_load) begin
                    if (!rsp) begin
                        w_stall   = 1'b1;
                        state_nxt = ST_WAIT;
                    end else begin
                        ld_capture = 1'b1;
                        if (stall_in) begin
                            state_nxt = ST_HELD;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (rsp) begin
                    ld_capture = 1'b1;
                    state_nxt  = stall_in ? ST_HELD : ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            ST_HELD: begin
                if (!stall_in) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ld_word = (state == ST_HELD) ? ld_buf : dmem_rdata;

    wb_stage_load_extend u_load_extend (
        .funct3 (w_inst[14:12]),
        .addr   (w_alu[1:0]),
        .word   (ld_word),
        .result (ld_data)
    );

    always_comb begin
        case (wb_sel)
            SEL_ALU: rf_wdata = w_alu;
            SEL_MEM: rf_wdata = ld_data;
            SEL_PC4: rf_wdata = w_pc + 32'd4;
            default: rf_wdata = '0;
        endcase
    end

    // Writing only on advance guarantees exactly one write as the instruction leaves W.
    assign rf_we = w_valid && rwe && advance && (w_inst[11:7] != 5'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_tohost <= '0;
        end else if (w_valid && csr_we && advance) begin
            csr_tohost <= w_csr_src;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (w_valid && advance) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: W-control decode, cycle driver with an instruction-level
// reference model, and a writeback scoreboard fed at issue and drained by a monitor.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam logic [6:0] OP_LD_T  = 7'b000_0011;
    localparam logic [6:0] OP_IMM_T = 7'b001_0011;
    localparam logic [6:0] OP_JAL_T = 7'b110_1111;
    localparam logic [6:0] OP_SYS_T = 7'b111_0011;
    localparam logic [6:0] OP_CUS_T = 7'b000_1011;
    localparam logic [6:0] OP_ST_T  = 7'b010_0011;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] inst;
        logic [31:0] csr_src;
        logic [31:0] word;
        int          lat;
        int          hold;
    } instr_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        x_valid = 1'b0;
    logic [31:0] x_pc = '0, x_alu = '0, x_inst = 32'h13, x_csr_src = '0;
    logic        stall_in = 1'b0, dmem_busy = 1'b0, dmem_resp_valid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [6:0]  ctl_opcode;
    logic [2:0]  ctl_funct3;
    logic [11:0] ctl_csr;
    logic [1:0]  wb_sel;
    logic        rwe, csr_we;
    logic        w_stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, csr_tohost, cycle_cnt, instret_cnt, dbg_inst;
    logic [1:0]  dbg_state;

    wb_stage dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .x_valid         (x_valid),
        .x_pc            (x_pc),
        .x_alu           (x_alu),
        .x_inst          (x_inst),
        .x_csr_src       (x_csr_src),
        .stall_in        (stall_in),
        .dmem_busy       (dmem_busy),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_rdata      (dmem_rdata),
        .ctl_opcode      (ctl_opcode),
        .ctl_funct3      (ctl_funct3),
        .ctl_csr         (ctl_csr),
        .wb_sel          (wb_sel),
        .rwe             (rwe),
        .csr_we          (csr_we),
        .w_stall         (w_stall),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .csr_tohost      (csr_tohost),
        .cycle_cnt       (cycle_cnt),
        .instret_cnt     (instret_cnt),
        .dbg_state       (dbg_state),
        .dbg_inst        (dbg_inst)
    );

    // W control decode, as the surrounding pipeline would provide it.
    always_comb begin
        wb_sel = SEL_ALU;
        rwe    = 1'b0;
        csr_we = 1'b0;
        case (ctl_opcode)
            OP_LD_T:  begin wb_sel = SEL_MEM; rwe = 1'b1; end
            OP_JAL_T: begin wb_sel = SEL_PC4; rwe = 1'b1; end
            OP_IMM_T: rwe = 1'b1;
            OP_CUS_T: begin wb_sel = 2'b11; rwe = 1'b1; end
            OP_SYS_T: csr_we = (ctl_funct3 == 3'b001) && (ctl_csr == CSR_TOHOST);
            default:  ;
        endcase
    end

    // ---------------- checking bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] sh_b, sh_h;
        sh_b = w >> (32'(a) * 8);
        sh_h = w >> (32'(a[1]) * 16);
        case (f3)
            3'b000:  return 32'($signed(sh_b[7:0]));
            3'b100:  return 32'(sh_b[7:0]);
            3'b001:  return 32'($signed(sh_h[15:0]));
            3'b101:  return 32'(sh_h[15:0]);
            3'b010:  return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit exp_write(input instr_t t, output logic [36:0] e);
        logic [31:0] d;
        bit wr;
        wr = 1'b1;
        d  = '0;
        case (t.inst[6:0])
            OP_LD_T:  d = ref_load(t.inst[14:12], t.alu[1:0], t.word);
            OP_IMM_T: d = t.alu;
            OP_JAL_T: d = t.pc + 32'd4;
            OP_CUS_T: d = 32'd0;
            default:  wr = 1'b0;
        endcase
        if (!t.valid || t.inst[11:7] == 5'd0) wr = 1'b0;
        e = {t.inst[11:7], d};
        return wr;
    endfunction

    function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                  input logic [11:0] imm, input logic [31:0] pc, input logic [31:0] alu,
                                  input logic [31:0] word, input int lat, input int hold);
        instr_t t;
        t.valid   = 1'b1;
        t.pc      = pc;
        t.alu     = alu;
        t.inst    = {imm, 5'($urandom_range(0, 31)), f3, rd, op};
        t.csr_src = $urandom();
        t.word    = word;
        t.lat     = lat;
        t.hold    = hold;
        return t;
    endfunction

    function automatic instr_t bubble();
        instr_t t;
        t = mk(OP_IMM_T, 3'b000, 5'd0, 12'd0, 32'd0, 32'd0, 32'd0, 0, 0);
        t.valid = 1'b0;
        t.inst  = 32'h0000_0013;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        logic [6:0] op;
        logic [2:0] f3;
        logic [11:0] imm;
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom());
        case ($urandom_range(0, 9))
            0, 1, 2: op = OP_LD_T;
            3, 4:    op = OP_IMM_T;
            5:       op = OP_JAL_T;
            6: begin
                op  = OP_SYS_T;
                if ($urandom_range(0, 1) == 1) f3 = 3'b001;
                imm = ($urandom_range(0, 1) == 1) ? 12'h51E : 12'h51F;
            end
            7:       op = OP_CUS_T;
            default: op = OP_ST_T;
        endcase
        t = mk(op, f3, 5'($urandom_range(0, 31)), imm, $urandom(), $urandom(), $urandom(),
               $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        t.valid = ($urandom_range(0, 7) != 0);
        return t;
    endfunction

    // Model of what sits in W and of the architectural counters.
    instr_t      w_m, pend;
    instr_t      prog_q[$];
    bit          w_rsp_done;
    int          w_wait, w_hold, w_cycles;
    logic [31:0] instret_exp, tohost_exp, cycle_exp;
    bit          rand_mode = 1'b0;
    int          junk_pct = 0;
    int          stall_seen = 0;

    function automatic instr_t next_instr();
        if (prog_q.size() > 0) return prog_q.pop_front();
        if (rand_mode) return rand_instr();
        return bubble();
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; drives one cycle, checks state, and returns at the next falling edge.
    task automatic step();
        logic is_ld, rsp, busy, stl, junk, exp_stall, exp_adv;
        logic [1:0]  exp_st;
        logic [36:0] e;
        is_ld = w_m.valid && (w_m.inst[6:0] == OP_LD_T);
        rsp   = 1'b0;
        busy  = 1'b0;
        if (is_ld && !w_rsp_done) begin
            if (w_wait > 0) begin
                busy = 1'b1;
                w_wait--;
            end else begin
                rsp = 1'b1;
            end
        end
        if (w_hold > 0 && (!is_ld || w_rsp_done || rsp)) begin
            stl = 1'b1;
            w_hold--;
        end else begin
            stl = rand_mode && ($urandom_range(0, 4) == 0);
        end
        junk = !(is_ld && !w_rsp_done) && ($urandom_range(0, 99) < junk_pct);

        stall_in        = stl;
        dmem_busy       = busy;
        dmem_resp_valid = rsp || junk;
        dmem_rdata      = rsp ? w_m.word : $urandom();
        x_valid         = pend.valid;
        x_pc            = pend.pc;
        x_alu           = pend.alu;
        x_inst          = pend.inst;
        x_csr_src       = pend.csr_src;

        exp_stall = is_ld && !w_rsp_done && !rsp;
        exp_adv   = !stl && !exp_stall;
        if (is_ld && w_rsp_done)     exp_st = ST_HELD;
        else if (is_ld && w_cycles > 0) exp_st = ST_WAIT;
        else                         exp_st = ST_IDLE;

        #1;
        chk("w_stall", 32'(w_stall), 32'(exp_stall));
        chk("load_state", 32'(dbg_state), 32'(exp_st));
        chk("w_inst", dbg_inst, w_m.inst);
        chk("ctl_fields", {10'd0, ctl_csr, ctl_funct3, ctl_opcode},
            {10'd0, w_m.inst[31:20], w_m.inst[14:12], w_m.inst[6:0]});
        chk("rf_waddr", 32'(rf_waddr), 32'(w_m.inst[11:7]));
        chk("csr_tohost", csr_tohost, tohost_exp);
        chk("instret_cnt", instret_cnt, instret_exp);
        chk("cycle_cnt", cycle_cnt, cycle_exp);
        if (w_stall) stall_seen++;

        @(posedge clk);
        cycle_exp++;
        if (rsp) w_rsp_done = 1'b1;
        if (exp_adv) begin
            if (w_m.valid) begin
                instret_exp++;
                if (w_m.inst[6:0] == OP_SYS_T && w_m.inst[14:12] == 3'b001 &&
                    w_m.inst[31:20] == CSR_TOHOST)
                    tohost_exp = w_m.csr_src;
            end
            if (exp_write(pend, e)) exp_q.push_back(e);
            w_m        = pend;
            w_rsp_done = 1'b0;
            w_cycles   = 0;
            w_wait     = pend.lat;
            w_hold     = pend.hold;
            pend       = next_instr();
        end else begin
            w_cycles++;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asserted at a falling edge; released at a later falling edge.
    task automatic do_reset();
        exp_q.delete();
        reset_n         = 1'b0;
        stall_in        = 1'b0;
        dmem_busy       = 1'b0;
        dmem_resp_valid = 1'b0;
        #1;
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("reset_w_stall", 32'(w_stall), 32'd0);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_tohost", csr_tohost, 32'd0);
        chk("reset_instret", instret_cnt, 32'd0);
        repeat (2) @(negedge clk);
        reset_n     = 1'b1;
        w_m         = bubble();
        w_m.inst    = NOP_INST;
        w_rsp_done  = 1'b0;
        w_wait      = 0;
        w_hold      = 0;
        w_cycles    = 0;
        cycle_exp   = '0;
        instret_exp = '0;
        tohost_exp  = '0;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [36:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: rd=%0d data=%h written, none required, at %0t",
                             rf_waddr, rf_wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_waddr", 32'(rf_waddr), 32'(e[36:32]));
                    chk("wb_wdata", rf_wdata, e[31:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int s0;
        instr_t t;
        pend = bubble();
        @(negedge clk);
        do_reset();

        // Idle after reset: only the cycle counter moves.
        run(10);
        chk("idle_cycle_cnt", cycle_cnt, 32'd10);
        chk("idle_instret", instret_cnt, 32'd0);
        chk("idle_tohost", csr_tohost, 32'd0);

        // Directed test-plan sequence.
        prog_q.push_back(mk(OP_LD_T, 3'b000, 5'd5, 12'd0, 32'h100, 32'h0000_1003, 32'h80FF_FF12, 0, 0));
        prog_q.push_back(mk(OP_LD_T, 3'b100, 5'd6, 12'd0, 32'h104, 32'h0000_1003, 32'h80FF_FF12, 0, 0));
        prog_q.push_back(mk(OP_LD_T, 3'b010, 5'd7, 12'd0, 32'h108, 32'h0000_2000, 32'hDEAD_BEEF, 3, 0));
        prog_q.push_back(mk(OP_LD_T, 3'b001, 5'd8, 12'd0, 32'h10C, 32'h0000_3002, 32'h8001_0000, 0, 2));
        prog_q.push_back(mk(OP_JAL_T, 3'b000, 5'd1, 12'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0));
        prog_q.push_back(mk(OP_JAL_T, 3'b000, 5'd0, 12'd0, 32'h0000_0040, 32'h0, 32'h0, 0, 0));
        t = mk(OP_SYS_T, 3'b001, 5'd0, 12'h51E, 32'h48, 32'h0, 32'h0, 0, 2);
        t.csr_src = 32'h1;
        prog_q.push_back(t);
        t = mk(OP_SYS_T, 3'b001, 5'd0, 12'h51F, 32'h4C, 32'h0, 32'h0, 0, 0);
        t.csr_src = 32'h55;
        prog_q.push_back(t);
        prog_q.push_back(mk(OP_CUS_T, 3'b000, 5'd9, 12'd0, 32'h50, 32'h1234_5678, 32'h0, 0, 0));
        prog_q.push_back(mk(OP_LD_T, 3'b011, 5'd10, 12'd0, 32'h54, 32'h0, 32'hFFFF_FFFF, 0, 0));
        prog_q.push_back(mk(OP_LD_T, 3'b101, 5'd11, 12'd0, 32'h58, 32'h0000_0001, 32'h1234_8765, 1, 0));
        prog_q.push_back(mk(OP_LD_T, 3'b001, 5'd12, 12'd0, 32'h5C, 32'h0000_0003, 32'hC001_0000, 0, 0));
        s0 = stall_seen;
        run(40);
        chk("directed_stall_cycles", 32'(stall_seen - s0), 32'd4);
        chk("directed_tohost", csr_tohost, 32'h1);

        // Randomized traffic with external stalls and stray responses.
        rand_mode = 1'b1;
        junk_pct  = 10;
        run(2500);
        rand_mode = 1'b0;
        junk_pct  = 0;
        run(12);

        // Reset in the middle of an outstanding load, then a late response.
        prog_q.push_back(mk(OP_LD_T, 3'b010, 5'd13, 12'd0, 32'h200, 32'h0, 32'hCAFE_F00D, 6, 0));
        run(3);
        do_reset();
        junk_pct = 100;
        run(3);
        junk_pct = 0;
        chk("post_reset_instret", instret_cnt, 32'd0);
        run(4);

        #4;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Stage-3 (W) datapath of the 3-stage RV32I pipeline. It holds the W pipeline register and exposes instruction fields to the W control decode. It consumes that decode's wb_sel/rwe/csr_we and aligns and sign-extends load data from the data cache. It drives the regfile write port and owns the tohost CSR and the cycle/instret counters. It stalls the pipeline while a load response is outstanding.

Parameters:
NOP_INST, 32'h0000_0013, instruction loaded into the W register at reset.
XLEN, 32, datapath width. Fixed; not to be overridden.

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
x_valid  in  1  X-stage instruction is real (not a bubble)
x_pc  in  32  X-stage PC
x_alu  in  32  ALU result; also the load address
x_inst  in  32  X-stage instruction
x_csr_src  in  32  CSR write source (rs1 value or zero-extended zimm)
stall_in  in  1  external stall (icache miss, etc.)
dmem_busy  in  1  dcache cannot return load data this cycle
dmem_resp_valid  in  1  dmem_rdata valid this cycle
dmem_rdata  in  32  raw aligned word from dcache
ctl_opcode  out  7  W-register opcode, to W control
ctl_funct3  out  3  W-register funct3, to W control
ctl_csr  out  12  W-register inst[31:20], to W control
wb_sel  in  2  writeback select from W control (ALU=0, MEM=1, PC4=2)
rwe  in  1  register write enable from W control
csr_we  in  1  tohost write enable from W control
w_stall  out  1  W requests a global stall
rf_we  out  1  regfile write strobe
rf_waddr  out  5  destination register
rf_wdata  out  32  writeback data; also the forwarding source
csr_tohost  out  32  CSR 0x51E
cycle_cnt  out  32  free-running cycle counter
instret_cnt  out  32  retired-instruction counter

Behaviour:
- advance = !stall_in && !w_stall. The W register (valid, pc, alu, inst, csr_src) loads from x_* only when advance=1 and holds otherwise.
- Reset values: w_valid=0, inst=NOP_INST, pc/alu/csr_src=0, FSM=IDLE, load buffer=0. Outputs: csr_tohost=0, cycle_cnt=0, instret_cnt=0, rf_we=0, w_stall=0.
- is_load = w_valid && opcode==LOAD.
- Load FSM:
  - IDLE: if is_load && !dmem_resp_valid → WAIT, w_stall=1. If is_load && dmem_resp_valid && stall_in → capture the word, go HELD.
  - WAIT: w_stall=1 until dmem_resp_valid. On dmem_resp_valid, capture the word. If stall_in → HELD, else → IDLE; the load retires that cycle from the bypassed word.
  - HELD: w_stall=0; use the buffered word. On advance → IDLE.
  - A response arriving in IDLE with no load in W is ignored.
- Load extract, combinational, on addr=alu[1:0]:
  - LB/LBU: byte addr, sign- or zero-extended.
  - LH/LHU: half addr[1], sign- or zero-extended. addr[0] is ignored; misalignment does not trap.
  - LW: whole word.
  - Other funct3: 0.
- rf_wdata: ALU→w_alu; MEM→extracted load; PC4→w_pc+4 (mod 2^32); 2'b11→0.
- rf_we = w_valid && rwe && advance && rd!=0. Each instruction writes exactly once, in the cycle it leaves W.
- rf_waddr = inst[11:7] at all times.
- csr_tohost <= w_csr_src when w_valid && csr_we && advance.
- cycle_cnt increments every cycle and wraps at 2^32.
- instret_cnt increments when w_valid && advance and wraps.
- Reset asserted mid-load: FSM → IDLE immediately; a response arriving after reset release is ignored.

Decomposition:
- Shared package (stage3 header): SEL_ALU/SEL_MEM/SEL_PC4 codes, load funct3 codes, CSR_TOHOST index, NOP_INST, FSM state encoding (IDLE/WAIT/HELD).
- One combinational sub-module, load_extend(funct3, addr[1:0], word) → 32-bit result.

Test Plan:
- Reset released, no valid instructions, 10 cycles → cycle_cnt=10, instret_cnt=0, rf_we never high, csr_tohost=0.
- LB, alu=0x...03, dmem_rdata=0x80FF_FF12, no busy → rf_wdata=0xFFFF_FF80, rf_we=1 for one cycle; LBU on the same word → 0x0000_0080.
- LW with dmem_busy for 3 cycles, then resp 0xDEAD_BEEF → w_stall high for exactly 3 cycles; single rf_we with 0xDEAD_BEEF; instret +1.
- LH, alu low bits=2, resp 0x8001_0000 arriving with stall_in=1 for 2 cycles → FSM in HELD; on release rf_wdata=0xFFFF_8001, one write only.
- JAL at pc=0xFFFF_FFFC with rd=x1 → rf_wdata=0x0000_0000 (wrap); JAL with rd=x0 → rf_we=0.
- csrrw 0x51E with csr_src=0x1 held under stall_in for 2 cycles → csr_tohost updates once, after stall release; csrrw to 0x51F leaves csr_tohost unchanged.
